// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial stream block.
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

  function automatic int cnt_w(input int b);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/parallel_to_serial_stream_beat_counter.sv
// Beat index counter: clear wins over increment, wraps after MAX.
module beat_counter
  import serializer_pkg::*;
#(
  parameter int MAX = 7,
  localparam int CW = cnt_w(MAX + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          INC,
  output logic [CW-1:0] COUNT,
  output logic          AT_MAX
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (CLR) begin
      count_d = '0;
    end else if (INC) begin
      count_d = (count_q == CW'(MAX)) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT  = count_q;
  assign AT_MAX = (count_q == CW'(MAX));

endmodule

// File: rtl/parallel_to_serial_stream.sv
// Streams a WIDTH-bit word out as LANES-bit beats over valid/ready,
// reloading on the last beat so consecutive words run without a bubble.
module parallel_to_serial_stream
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             ABORT,
  output logic [LANES-1:0] DATA_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST
);

  localparam int BEATS = beats(WIDTH, LANES);
  localparam int CW    = cnt_w(BEATS);

  if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of LANES");
  end

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] sreg_shift;
  logic [LANES-1:0] beat;
  logic [CW-1:0]    cnt;
  logic             at_max;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             shifting;
  logic             accept;
  logic             xfer;

  beat_counter #(
    .MAX(BEATS - 1)
  ) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (cnt_clr),
    .INC   (cnt_inc),
    .COUNT (cnt),
    .AT_MAX(at_max)
  );

  if (MSB_FIRST) begin : g_msb
    assign beat       = sreg_q[WIDTH-1 -: LANES];
    assign sreg_shift = sreg_q << LANES;
  end else begin : g_lsb
    assign beat       = sreg_q[LANES-1:0];
    assign sreg_shift = sreg_q >> LANES;
  end

  assign shifting  = (state_q == SHIFT);
  assign OUT_VALID = shifting;
  assign OUT_LAST  = shifting && at_max;
  assign DATA_OUT  = shifting ? beat : '0;

  // Ready on the last accepted beat so the next word loads in its place.
  assign IN_READY = !RST && !ABORT &&
                    (!shifting || (OUT_READY && OUT_LAST));

  assign accept = IN_VALID && IN_READY;
  assign xfer   = shifting && OUT_READY;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (ABORT) begin
      state_d = IDLE;
      sreg_d  = '0;
      cnt_clr = 1'b1;
    end else if (accept) begin
      state_d = SHIFT;
      sreg_d  = DATA_IN;
      cnt_clr = 1'b1;
    end else if (xfer) begin
      if (at_max) begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_clr = 1'b1;
      end else begin
        sreg_d  = sreg_shift;
        cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// Scoreboard bench for parallel_to_serial_stream: LSB, MSB and
// full-width instances sharing one clock and reset.
module tb_parallel_to_serial_stream;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_data = '0, b_data = '0;
  logic [3:0] c_data = '0;
  logic a_in_valid = 0, b_in_valid = 0, c_in_valid = 0;
  logic a_abort = 0, b_abort = 0, c_abort = 0;
  logic a_out_ready = 1, b_out_ready = 1, c_out_ready = 1;
  logic a_in_ready, b_in_ready, c_in_ready;
  logic a_out_valid, b_out_valid, c_out_valid;
  logic a_out_last, b_out_last, c_out_last;
  logic [1:0] a_data_out, b_data_out;
  logic [3:0] c_data_out;

  int checks = 0;
  int failures = 0;
  beat_t q[$];

  parallel_to_serial_stream #(
    .WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)
  ) u_a (
    .CLK(clk), .RST(rst), .DATA_IN(a_data), .IN_VALID(a_in_valid),
    .IN_READY(a_in_ready), .ABORT(a_abort), .DATA_OUT(a_data_out),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready),
    .OUT_LAST(a_out_last)
  );

  parallel_to_serial_stream #(
    .WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)
  ) u_b (
    .CLK(clk), .RST(rst), .DATA_IN(b_data), .IN_VALID(b_in_valid),
    .IN_READY(b_in_ready), .ABORT(b_abort), .DATA_OUT(b_data_out),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready),
    .OUT_LAST(b_out_last)
  );

  parallel_to_serial_stream #(
    .WIDTH(4), .LANES(4), .MSB_FIRST(1'b0)
  ) u_c (
    .CLK(clk), .RST(rst), .DATA_IN(c_data), .IN_VALID(c_in_valid),
    .IN_READY(c_in_ready), .ABORT(c_abort), .DATA_OUT(c_data_out),
    .OUT_VALID(c_out_valid), .OUT_READY(c_out_ready),
    .OUT_LAST(c_out_last)
  );

  // Reference beats taken by bit index straight from the word.
  task automatic push_word(input logic [7:0] w, input int width,
                           input int lanes, input bit msb);
    int nb, sh, mask;
    beat_t e;
    nb   = width / lanes;
    mask = (1 << lanes) - 1;
    for (int i = 0; i < nb; i++) begin
      sh     = msb ? (width - lanes * (i + 1)) : (lanes * i);
      e.d    = 8'((int'(w) >> sh) & mask);
      e.last = (i == nb - 1);
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 ||
        a_out_last !== 1'b0 || a_data_out !== 2'b00) begin
      failures++;
      $display("FAIL reset_a rdy=%b vld=%b last=%b data=%h exp 0/0/0/0",
               a_in_ready, a_out_valid, a_out_last, a_data_out);
    end
    checks++;
    if (c_out_valid !== 1'b0 || c_data_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_c vld=%b data=%h exp 0/0",
               c_out_valid, c_data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release rdy_a=%b rdy_c=%b exp 1/1",
               a_in_ready, c_in_ready);
    end
  endtask

  task automatic test_lsb();
    beat_t e;
    q.delete();
    push_word(8'hB4, 8, 2, 1'b0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin a_data = 8'hB4; a_in_valid = 1'b1; end
      if (c == 1) a_in_valid = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== (c >= 1 && c <= 4)) begin
        failures++;
        $display("FAIL lsb_valid c=%0d got=%b", c, a_out_valid);
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL lsb_beat extra data=%h", a_data_out);
        end else begin
          e = q.pop_front();
          if ({6'b0, a_data_out} !== e.d || a_out_last !== e.last) begin
            failures++;
            $display("FAIL lsb_beat got=%h/%b exp=%h/%b",
                     a_data_out, a_out_last, e.d, e.last);
          end
        end
      end else if (a_data_out !== 2'b00 || a_out_last !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL lsb_idle data=%h last=%b exp 0/0",
                 a_data_out, a_out_last);
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL lsb_missing left=%0d exp 0", q.size());
    end
  endtask

  task automatic test_msb();
    beat_t e;
    q.delete();
    push_word(8'hB4, 8, 2, 1'b1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin b_data = 8'hB4; b_in_valid = 1'b1; end
      if (c == 1) b_in_valid = 1'b0;
      #1;
      checks++;
      if (b_out_valid !== (c >= 1 && c <= 4)) begin
        failures++;
        $display("FAIL msb_valid c=%0d got=%b", c, b_out_valid);
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL msb_beat extra data=%h", b_data_out);
        end else begin
          e = q.pop_front();
          if ({6'b0, b_data_out} !== e.d || b_out_last !== e.last) begin
            failures++;
            $display("FAIL msb_beat got=%h/%b exp=%h/%b",
                     b_data_out, b_out_last, e.d, e.last);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0 || b_data_out !== 2'b00) begin
      failures++;
      $display("FAIL msb_end left=%0d data=%h exp 0/0",
               q.size(), b_data_out);
    end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    logic exp_rdy;
    q.delete();
    push_word(8'hB4, 8, 2, 1'b0);
    push_word(8'hFF, 8, 2, 1'b0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) begin a_data = 8'hB4; a_in_valid = 1'b1; end
      if (c == 1) a_data = 8'hFF;
      if (c == 5) a_in_valid = 1'b0;
      #1;
      exp_rdy = (c == 0 || c == 4 || c >= 8);
      checks++;
      if (a_in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL b2b_ready c=%0d got=%b exp=%b",
                 c, a_in_ready, exp_rdy);
      end
      checks++;
      if (a_out_valid !== (c >= 1 && c <= 8)) begin
        failures++;
        $display("FAIL b2b_valid c=%0d got=%b", c, a_out_valid);
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_beat extra data=%h", a_data_out);
        end else begin
          e = q.pop_front();
          if ({6'b0, a_data_out} !== e.d || a_out_last !== e.last) begin
            failures++;
            $display("FAIL b2b_beat c=%0d got=%h/%b exp=%h/%b",
                     c, a_data_out, a_out_last, e.d, e.last);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing left=%0d exp 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    q.delete();
    push_word(8'hB4, 8, 2, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin a_data = 8'hB4; a_in_valid = 1'b1; end
      if (c == 1) a_in_valid = 1'b0;
      if (c == 2) a_out_ready = 1'b0;
      if (c == 5) a_out_ready = 1'b1;
      #1;
      checks++;
      if (a_out_valid !== (c >= 1 && c <= 7)) begin
        failures++;
        $display("FAIL bp_valid c=%0d got=%b", c, a_out_valid);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (a_data_out !== 2'b01 || a_out_last !== 1'b0 ||
            a_in_ready !== 1'b0 || u_a.cnt !== 2'd1) begin
          failures++;
          $display("FAIL bp_hold c=%0d data=%h last=%b rdy=%b cnt=%0d exp 1/0/0/1",
                   c, a_data_out, a_out_last, a_in_ready, u_a.cnt);
        end
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_beat extra data=%h", a_data_out);
        end else begin
          e = q.pop_front();
          if ({6'b0, a_data_out} !== e.d || a_out_last !== e.last) begin
            failures++;
            $display("FAIL bp_beat c=%0d got=%h/%b exp=%h/%b",
                     c, a_data_out, a_out_last, e.d, e.last);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL bp_missing left=%0d exp 0", q.size());
    end
  endtask

  task automatic test_abort();
    beat_t e;
    q.delete();
    push_word(8'hB4, 8, 2, 1'b0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) begin a_data = 8'hB4; a_in_valid = 1'b1; end
      if (c == 1) a_in_valid = 1'b0;
      if (c == 3) begin
        a_abort = 1'b1; a_data = 8'h3C; a_in_valid = 1'b1;
      end
      if (c == 4) a_abort = 1'b0;
      if (c == 5) a_in_valid = 1'b0;
      #1;
      if (c == 3) begin
        checks++;
        if (a_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL abort_ready got=%b exp=0", a_in_ready);
        end
        q.delete();
        push_word(8'h3C, 8, 2, 1'b0);
      end else if (c == 4) begin
        checks++;
        if (a_out_valid !== 1'b0 || a_data_out !== 2'b00 ||
            a_in_ready !== 1'b1) begin
          failures++;
          $display("FAIL abort_after vld=%b data=%h rdy=%b exp 0/0/1",
                   a_out_valid, a_data_out, a_in_ready);
        end
      end else if (a_out_valid && a_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL abort_beat extra data=%h", a_data_out);
        end else begin
          e = q.pop_front();
          if ({6'b0, a_data_out} !== e.d || a_out_last !== e.last) begin
            failures++;
            $display("FAIL abort_beat c=%0d got=%h/%b exp=%h/%b",
                     c, a_data_out, a_out_last, e.d, e.last);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL abort_missing left=%0d exp 0", q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin a_data = 8'hB4; a_in_valid = 1'b1; end
      if (c == 1) a_in_valid = 1'b0;
      if (c == 2) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      #1;
      if (c == 2) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_pre vld=%b rdy=%b exp 1/0",
                   a_out_valid, a_in_ready);
        end
      end
      if (c == 3) begin
        checks++;
        if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 ||
            a_data_out !== 2'b00 || a_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_hold vld=%b last=%b data=%h rdy=%b exp 0/0/0/0",
                   a_out_valid, a_out_last, a_data_out, a_in_ready);
        end
      end
      if (c == 4) begin
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_release rdy=%b vld=%b exp 1/0",
                   a_in_ready, a_out_valid);
        end
      end
    end
  endtask

  task automatic test_full_width();
    beat_t e;
    q.delete();
    push_word(8'h0A, 4, 4, 1'b0);
    push_word(8'h05, 4, 4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin c_data = 4'hA; c_in_valid = 1'b1; end
      if (c == 1) c_data = 4'h5;
      if (c == 2) c_in_valid = 1'b0;
      #1;
      checks++;
      if (c_out_valid !== (c == 1 || c == 2) ||
          c_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL fw_flow c=%0d vld=%b rdy=%b", c,
                 c_out_valid, c_in_ready);
      end
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL fw_beat extra data=%h", c_data_out);
        end else begin
          e = q.pop_front();
          if ({4'b0, c_data_out} !== e.d || c_out_last !== e.last) begin
            failures++;
            $display("FAIL fw_beat c=%0d got=%h/%b exp=%h/%b",
                     c, c_data_out, c_out_last, e.d, e.last);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL fw_missing left=%0d exp 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_lsb();
    test_msb();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_full_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
